// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder
// Snoops a multiplexed seven-segment scan bus (active-low cathodes and anodes),
// waits for each digit slot to settle, decodes the glyph back to a hex nibble
// plus decimal point, and publishes a complete frame once every digit was seen.
module sseg_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              sseg_ca,
    input  logic [7:0]              sseg_an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    frame_valid
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [7:0]              ca_reg, an_reg;
    logic [7:0]              ca_prev_reg, an_prev_reg;
    logic [NUM_DIGITS-1:0]   seen_reg, seen_next;
    logic [NUM_DIGITS-1:0]   slot_sel;
    logic                    slot_active;
    logic [IDX_W-1:0]        slot_idx;
    logic                    pair_changed;
    logic                    capture;
    logic                    frame_fire;
    logic [3:0]              glyph_nib;
    logic                    glyph_ok;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_ok;

    // Active-low 7-segment code (bit0 = a .. bit6 = g) back to {legal, nibble}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h40:   res = {1'b1, 4'h0};
            7'h79:   res = {1'b1, 4'h1};
            7'h24:   res = {1'b1, 4'h2};
            7'h30:   res = {1'b1, 4'h3};
            7'h19:   res = {1'b1, 4'h4};
            7'h12:   res = {1'b1, 4'h5};
            7'h02:   res = {1'b1, 4'h6};
            7'h78:   res = {1'b1, 4'h7};
            7'h00:   res = {1'b1, 4'h8};
            7'h10:   res = {1'b1, 4'h9};
            7'h08:   res = {1'b1, 4'hA};
            7'h03:   res = {1'b1, 4'hB};
            7'h46:   res = {1'b1, 4'hC};
            7'h21:   res = {1'b1, 4'hD};
            7'h06:   res = {1'b1, 4'hE};
            7'h0E:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    // Register the scan bus once, and keep the previous registered pair for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca_reg      <= 8'hFF;
            an_reg      <= 8'hFF;
            ca_prev_reg <= 8'hFF;
            an_prev_reg <= 8'hFF;
        end else begin
            ca_reg      <= sseg_ca;
            an_reg      <= sseg_an;
            ca_prev_reg <= ca_reg;
            an_prev_reg <= an_reg;
        end
    end

    assign slot_sel     = ~an_reg[NUM_DIGITS-1:0];
    assign slot_active  = $onehot(slot_sel);
    assign pair_changed = (ca_reg != ca_prev_reg) || (an_reg != an_prev_reg);
    assign frame_fire   = (seen_reg == {NUM_DIGITS{1'b1}});
    assign {glyph_ok, glyph_nib} = decode_glyph(ca_reg[6:0]);

    // Index of the single lit anode (meaningful only while slot_active).
    always_comb begin
        slot_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_sel[i]) begin
                slot_idx = IDX_W'(i);
            end
        end
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state: settle on a one-hot slot, capture once stable, hold until the pair moves.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (slot_active) begin
                    state_next = SETTLE;
                    cnt_next   = CNT_W'(1);
                end
            end
            SETTLE: begin
                if (pair_changed) begin
                    state_next = slot_active ? SETTLE : IDLE;
                    cnt_next   = CNT_W'(1);
                end else if (cnt_reg == CNT_W'(STABLE_CYCLES)) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HOLD: begin
                if (pair_changed) begin
                    state_next = slot_active ? SETTLE : IDLE;
                    cnt_next   = CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Seen mask clears when a frame is published; a same-cycle capture opens the next frame.
    always_comb begin
        seen_next = frame_fire ? '0 : seen_reg;
        if (capture) begin
            seen_next[slot_idx] = 1'b1;
        end
    end

    // Seen-mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_reg <= '0;
        end else begin
            seen_reg <= seen_next;
        end
    end

    // One shadow slot per digit; the latest capture of a digit wins until the frame is published.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
            logic [3:0] nib_reg;
            logic       dp_reg;
            logic       ok_reg;

            // Capture the decoded glyph when this digit's slot is the one being captured.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    nib_reg <= 4'h0;
                    dp_reg  <= 1'b0;
                    ok_reg  <= 1'b0;
                end else if (capture && (slot_idx == IDX_W'(gi))) begin
                    nib_reg <= glyph_nib;
                    dp_reg  <= ~ca_reg[7];
                    ok_reg  <= glyph_ok;
                end
            end

            assign shadow_digits[4*gi +: 4] = nib_reg;
            assign shadow_dp[gi]            = dp_reg;
            assign shadow_ok[gi]            = ok_reg;
        end
    endgenerate

    // Publish the completed frame and pulse frame_valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            dp          <= '0;
            digit_ok    <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_fire;
            if (frame_fire) begin
                digits   <= shadow_digits;
                dp       <= shadow_dp;
                digit_ok <= shadow_ok;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb_sseg_scan_decoder
// Drives scan sequences onto the seven-segment bus, queues the frame each
// complete scan should produce, and compares published frames against the queue.
module tb_sseg_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sseg_ca;
    logic [7:0]  sseg_an;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  digit_ok;
    logic        frame_valid;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  p;
        logic [7:0]  k;
    } frame_t;

    frame_t      exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frames_seen = 0;
    int          frames_pushed = 0;
    logic        prev_fv = 1'b0;
    logic [47:0] last_out = '0;

    sseg_scan_decoder #(
        .NUM_DIGITS    (8),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sseg_ca     (sseg_ca),
        .sseg_an     (sseg_an),
        .digits      (digits),
        .dp          (dp),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Active-low segment pattern for each hex digit as a real display driver emits it.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
            4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
            4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
            4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic frame_t make_exp(input logic [31:0] val, input logic [7:0] dpm,
                                        input logic [7:0] blankm);
        frame_t f;
        f.d = val;
        f.p = dpm;
        f.k = ~blankm;
        for (int i = 0; i < 8; i++) begin
            if (blankm[i]) f.d[4*i +: 4] = 4'h0;
        end
        return f;
    endfunction

    task automatic push_exp(input frame_t f);
        exp_q.push_back(f);
        frames_pushed++;
    endtask

    // One digit slot; called and returns at 1 time unit after a rising edge.
    task automatic show_slot(input int i, input logic [3:0] n, input logic d,
                             input logic blank, input int cyc);
        sseg_an = ~(8'h01 << i);
        sseg_ca = {~d, blank ? 7'h7F : seg_code(n)};
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [31:0] val, input logic [7:0] dpm, input logic [7:0] blankm,
                        input int cyc, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            show_slot(i, val[4*i +: 4], dpm[i], blankm[i], cyc);
        end
    endtask

    task automatic idle(input int cyc);
        sseg_an = 8'hFF;
        sseg_ca = 8'hFF;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every published frame must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            frames_seen++;
            check_eq("frame_expected", exp_q.size() > 0, 1'b1);
            check_eq("fv_single", prev_fv, 1'b0);
            if (exp_q.size() > 0) begin
                frame_t e;
                e = exp_q.pop_front();
                $display("frame %0d: digits=%h dp=%h ok=%h (exp %h %h %h)",
                         frames_seen, digits, dp, digit_ok, e.d, e.p, e.k);
                check_eq("digits", digits, e.d);
                check_eq("dp", dp, e.p);
                check_eq("digit_ok", digit_ok, e.k);
            end
        end
        if (rst_n && !frame_valid) begin
            check_eq("out_stable", {digits, dp, digit_ok}, last_out);
        end
        last_out = {digits, dp, digit_ok};
        prev_fv  = frame_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        sseg_an = 8'hFF;
        sseg_ca = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_digits", digits, 32'h0);
        check_eq("rst_dp", dp, 8'h0);
        check_eq("rst_ok", digit_ok, 8'h0);
        check_eq("rst_fv", frame_valid, 1'b0);
        rst_n = 1'b1;
        idle(4);

        // Basic scan with a decimal point on digit 3.
        push_exp(make_exp(32'h1234ABCD, 8'h08, 8'h00));
        scan(32'h1234ABCD, 8'h08, 8'h00, 6, 0, 7);
        idle(10);

        // Slots shorter than the settle time never capture.
        scan(32'h1234ABCD, 8'h08, 8'h00, 3, 0, 7);
        idle(10);

        // Blank digit 5 decodes as illegal glyph but the frame is still issued.
        push_exp(make_exp(32'h89ABCDEF, 8'h00, 8'h20));
        scan(32'h89ABCDEF, 8'h00, 8'h20, 6, 0, 7);
        idle(10);

        // Multi-hot anodes mid-scan are ignored.
        push_exp(make_exp(32'h01234567, 8'h81, 8'h00));
        scan(32'h01234567, 8'h81, 8'h00, 6, 0, 3);
        sseg_an = 8'hFC;
        sseg_ca = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        scan(32'h01234567, 8'h81, 8'h00, 6, 4, 7);
        idle(10);

        // Reset in the middle of settling discards the partial frame.
        scan(32'hFFFFFFFF, 8'hFF, 8'h00, 6, 0, 4);
        show_slot(5, 4'hF, 1'b1, 1'b0, 2);
        rst_n = 1'b0;
        #2;
        check_eq("midrst_digits", digits, 32'h0);
        check_eq("midrst_dp", dp, 8'h0);
        check_eq("midrst_ok", digit_ok, 8'h0);
        check_eq("midrst_fv", frame_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        scan(32'hFEDCBA98, 8'h40, 8'h00, 6, 5, 7);
        idle(10);
        push_exp(make_exp(32'hFEDCBA98, 8'h40, 8'h00));
        scan(32'hFEDCBA98, 8'h40, 8'h00, 6, 0, 4);
        idle(10);

        // Digit 2 recaptured (3 then 7) before completion; latest value wins.
        push_exp(make_exp(32'h4C5F0781, 8'h00, 8'h00));
        scan(32'h4C5F0781, 8'h00, 8'h00, 6, 0, 1);
        show_slot(2, 4'h3, 1'b0, 1'b0, 6);
        scan(32'h4C5F0781, 8'h00, 8'h00, 6, 3, 3);
        scan(32'h4C5F0781, 8'h00, 8'h00, 6, 2, 7);

        // Back-to-back frame with no gap: seen mask must restart cleanly.
        push_exp(make_exp(32'h13579BDF, 8'h24, 8'h00));
        scan(32'h13579BDF, 8'h24, 8'h00, 6, 0, 7);
        idle(20);

        check_eq("queue_empty", exp_q.size(), 0);
        check_eq("frame_count", frames_seen, frames_pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
